// File: rtl/ssd_pkg.sv
// Shared constants and types for the 4-digit seven-segment scanner.
// Segment codes are active-low {a,b,c,d,e,f,g,dp}; anode codes are active-low.
package ssd_pkg;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_SEL0 = 4'b1110;
    localparam logic [3:0] AN_SEL1 = 4'b1101;
    localparam logic [3:0] AN_SEL2 = 4'b1011;
    localparam logic [3:0] AN_SEL3 = 4'b0111;

    typedef logic [1:0] scan_idx_t;

    // Captured display payload: d0 = thousands .. d3 = ones, dp by anode position.
    typedef struct packed {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [3:0] dp;
    } shadow_t;

    function automatic logic [3:0] an_sel(input scan_idx_t idx);
        logic [3:0] an;
        an = AN_OFF;
        case (idx)
            2'd0: an = AN_SEL0;
            2'd1: an = AN_SEL1;
            2'd2: an = AN_SEL2;
            2'd3: an = AN_SEL3;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low {a..g} glyph; 10-15 render as a dash,
// blank_i forces all segments off.
module bcd_to_seg (
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_c
);
    import ssd_pkg::*;

    always_comb begin
        seg_c = SEG_DASH[7:1];
        if (blank_i) begin
            seg_c = SEG_BLANK[7:1];
        end else begin
            case (digit_i)
                4'd0:    seg_c = SEG_0[7:1];
                4'd1:    seg_c = SEG_1[7:1];
                4'd2:    seg_c = SEG_2[7:1];
                4'd3:    seg_c = SEG_3[7:1];
                4'd4:    seg_c = SEG_4[7:1];
                4'd5:    seg_c = SEG_5[7:1];
                4'd6:    seg_c = SEG_6[7:1];
                4'd7:    seg_c = SEG_7[7:1];
                4'd8:    seg_c = SEG_8[7:1];
                4'd9:    seg_c = SEG_9[7:1];
                default: seg_c = SEG_DASH[7:1];
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan4.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with leading-zero
// blanking and per-digit dp. Optional blink gating under macro SSD_BLINK_EN.
module ssd_scan4 #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp_en,
    input  logic       blink,
    output logic [3:0] ssd_an,
    output logic [7:0] ssd_seg,
    output logic       frame_done
);
    import ssd_pkg::*;

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    scan_idx_t        idx_q, idx_d;
    shadow_t          shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             fd_q, fd_d;

    logic             tick_c;
    logic             frame_wrap_c;
    logic [3:0]       cur_dig_c;
    logic             blank_c;
    logic [6:0]       glyph_c;
    logic             force_off_c;

    // Refresh divider, scan index and shadow capture.
    always_comb begin
        tick_c       = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_wrap_c = tick_c && (idx_q == 2'd3);
        div_d        = tick_c ? '0 : div_q + DIV_W'(1);
        idx_d        = tick_c ? scan_idx_t'(idx_q + 2'd1) : idx_q;
        shadow_d     = load ? {dig0, dig1, dig2, dig3, dp_en} : shadow_q;
        fd_d         = frame_wrap_c;
    end

    // Digit select; a position blanks only when it and everything left of it is zero.
    always_comb begin
        cur_dig_c = shadow_q.d3;
        blank_c   = 1'b0;
        case (idx_q)
            2'd0: begin
                cur_dig_c = shadow_q.d3;
                blank_c   = 1'b0;
            end
            2'd1: begin
                cur_dig_c = shadow_q.d2;
                blank_c   = (shadow_q.d0 == 4'd0) && (shadow_q.d1 == 4'd0)
                            && (shadow_q.d2 == 4'd0);
            end
            2'd2: begin
                cur_dig_c = shadow_q.d1;
                blank_c   = (shadow_q.d0 == 4'd0) && (shadow_q.d1 == 4'd0);
            end
            2'd3: begin
                cur_dig_c = shadow_q.d0;
                blank_c   = (shadow_q.d0 == 4'd0);
            end
            default: begin
                cur_dig_c = shadow_q.d3;
                blank_c   = 1'b0;
            end
        endcase
    end

    bcd_to_seg u_dec (
        .digit_i (cur_dig_c),
        .blank_i (blank_c),
        .seg_c   (glyph_c)
    );

    always_comb begin
        an_d  = force_off_c ? AN_OFF : an_sel(idx_q);
        seg_d = {glyph_c, ~shadow_q.dp[idx_q]};
    end

`ifdef SSD_BLINK_EN
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    // Frame counter toggles the blink phase every BLINK_FRAMES frames.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_wrap_c) begin
            if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign force_off_c = blink && phase_q;
`else
    logic [FC_W:0] unused_blink;
    assign unused_blink = {blink, FC_W'(BLINK_FRAMES - 1)};
    assign force_off_c  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
            fd_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign ssd_an     = an_q;
    assign ssd_seg    = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan4.sv
// Self-checking bench for ssd_scan4 (SCAN_DIV = 4, BLINK_FRAMES = 2).
// Honours SSD_BLINK_EN so the model matches whichever build is compiled.
module tb_ssd_scan4;

    localparam int unsigned SD    = 4;
    localparam int unsigned BF    = 2;
    localparam int unsigned FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst, load, blink;
    logic [3:0] dig0, dig1, dig2, dig3, dp_en;
    logic [3:0] ssd_an;
    logic [7:0] ssd_seg;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_scan4 #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dp_en      (dp_en),
        .blink      (blink),
        .ssd_an     (ssd_an),
        .ssd_seg    (ssd_seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position p (0 = ones) shown during slot ((n-1)/SD)%4 after n edges.
    logic [7:0] glyph [0:9] = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                                8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
                                8'b0000_0001, 8'b0000_1001};
    logic [3:0] m_dig [0:3];
    logic [3:0] m_dp;
    logic       mvalid = 1'b0;
    int         n;
    int         p;
    logic       bl;
    logic [7:0] g;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;

    always @(posedge clk) begin
        if (rst) begin
            n       = 0;
            mvalid  = 1'b1;
            for (int q = 0; q < 4; q++) m_dig[q] = 4'd0;
            m_dp    = 4'd0;
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
            exp_fd  = 1'b0;
        end else if (mvalid) begin
            n++;
            p  = ((n - 1) / SD) % 4;
            bl = (p > 0);
            for (int q = 0; q < 4; q++)
                if (q >= p && m_dig[q] != 4'd0) bl = 1'b0;
            if (bl)               g = 8'hFF;
            else if (m_dig[p] > 9) g = 8'b1111_1101;
            else                  g = glyph[m_dig[p]];
            exp_seg = {g[7:1], ~m_dp[p]};
            exp_an  = 4'b1111 ^ (4'b0001 << p);
`ifdef SSD_BLINK_EN
            if (blink && ((((n - 1) / FRAME) / BF) % 2 == 1)) exp_an = 4'hF;
`endif
            exp_fd = ((n % FRAME) == 0);
            if (load) begin
                m_dig[0] = dig3;
                m_dig[1] = dig2;
                m_dig[2] = dig1;
                m_dig[3] = dig0;
                m_dp     = dp_en;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_an", 32'(ssd_an), 32'(exp_an));
            check("model_seg", 32'(ssd_seg), 32'(exp_seg));
            check("model_frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    task automatic wait_an(input logic [3:0] t);
        int k;
        k = 0;
        while (ssd_an !== t && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (k >= 64) check("wait_an_timeout", 32'(ssd_an), 32'(t));
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] dp);
        load = 1'b1; dig0 = a; dig1 = b; dig2 = c; dig3 = d; dp_en = dp;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    int fdc;
    int offc;

    initial begin
        rst = 1'b1; load = 1'b0; blink = 1'b0;
        dig0 = 4'd0; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0; dp_en = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(ssd_an), 32'h0F);
        check("reset_seg", 32'(ssd_seg), 32'hFF);
        check("reset_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_an", 32'(ssd_an), 32'(4'b1110));
        check("first_seg_zero", 32'(ssd_seg), 32'(8'b0000_0011));

        fdc = 0;
        repeat (32) begin
            @(negedge clk);
            fdc += int'(frame_done);
        end
        check("frame_done_count", 32'(fdc), 32'd2);

        // Load 1,2,3,4 at the first cycle of the ones slot to measure latency.
        wait_an(4'b1101);
        wait_an(4'b1110);
        load = 1'b1; dig0 = 4'd1; dig1 = 4'd2; dig2 = 4'd3; dig3 = 4'd4; dp_en = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        check("latency_old", 32'(ssd_seg), 32'(8'b0000_0011));
        @(negedge clk);
        check("latency_new", 32'(ssd_seg), 32'(8'b1001_1001));
        wait_an(4'b0111);
        check("thousands_1", 32'(ssd_seg), 32'(8'b1001_1111));
        wait_an(4'b1011);
        check("hundreds_2_dp", 32'(ssd_seg), 32'(8'b0010_0100));
        wait_an(4'b1101);
        check("tens_3", 32'(ssd_seg), 32'(8'b0000_1101));

        do_load(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
        wait_an(4'b0111);
        check("blank_thousands", 32'(ssd_seg), 32'hFF);
        wait_an(4'b1011);
        check("blank_hundreds", 32'(ssd_seg), 32'hFF);
        wait_an(4'b1101);
        check("tens_5", 32'(ssd_seg), 32'(8'b0100_1001));
        wait_an(4'b1110);
        check("ones_0", 32'(ssd_seg), 32'(8'b0000_0011));

        do_load(4'd0, 4'd12, 4'd0, 4'd0, 4'b0000);
        wait_an(4'b1011);
        check("dash_hundreds", 32'(ssd_seg), 32'(8'b1111_1101));
        wait_an(4'b0111);
        check("dash_thousands_blank", 32'(ssd_seg), 32'hFF);
        wait_an(4'b1101);
        check("tens_zero_shown", 32'(ssd_seg), 32'(8'b0000_0011));

        // Load held high, changing every cycle, across several ticks.
        for (int i = 0; i < 12; i++) begin
            load  = 1'b1;
            dig0  = 4'($urandom_range(0, 15));
            dig1  = 4'($urandom_range(0, 15));
            dig2  = 4'($urandom_range(0, 15));
            dig3  = 4'($urandom_range(0, 15));
            dp_en = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        load = 1'b0;
        repeat (20) @(negedge clk);

        // Reset asserted mid-slot at index 2.
        wait_an(4'b1011);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_an", 32'(ssd_an), 32'h0F);
        check("midreset_seg", 32'(ssd_seg), 32'hFF);
        check("midreset_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_an", 32'(ssd_an), 32'(4'b1110));

        do_load(4'd9, 4'd8, 4'd7, 4'd6, 4'b1001);
        blink = 1'b1;
        repeat (8) @(negedge clk);
        offc = 0;
        fdc  = 0;
        repeat (4 * FRAME) begin
            @(negedge clk);
            offc += int'(ssd_an == 4'hF);
            fdc  += int'(frame_done);
        end
`ifdef SSD_BLINK_EN
        check("blink_off_cycles", 32'(offc), 32'(2 * FRAME));
`else
        check("blink_off_cycles", 32'(offc), 32'd0);
`endif
        check("blink_frame_done", 32'(fdc), 32'd4);
        blink = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
